// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, mode encodings and GF(2^8) helpers
package aes_pkg;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        MODE_128 = 2'b00,
        MODE_192 = 2'b01,
        MODE_256 = 2'b10,
        MODE_BAD = 2'b11
    } aes_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    function automatic logic [5:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return 6'd4;
            MODE_192: return 6'd6;
            default:  return 6'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return 4'd10;
            MODE_192: return 4'd12;
            default:  return 4'd14;
        endcase
    endfunction

    // 4*(Nr+1)-1 == 4*Nr+3, so the last word index is just Nr with two ones appended
    function automatic logic [5:0] last_of(input logic [1:0] mode);
        return {nr_of(mode), 2'b11};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - forward AES S-box as a constant lookup table
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);

    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // entry 0 sits in the top byte of the table
    assign sub = TABLE[11'd2047 - {data, 3'b000} -: 8];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - sequential AES key expansion, one round-key word per clock
module aes_key_schedule_seq
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [255:0]  key,
    output logic [1919:0] words,
    output logic          words_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    ks_state_e   state;
    logic [1:0]  mode_q;
    logic [5:0]  idx;
    logic [2:0]  grp;
    logic [7:0]  rcon;
    logic [31:0] w [MAX_WORDS];

    logic [5:0]  nk;
    logic [5:0]  last_idx;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;

    assign nk        = nk_of(mode_q);
    assign last_idx  = last_of(mode_q);
    assign prev_word = w[idx - 6'd1];
    assign back_word = w[idx - nk];

    // RotWord only applies at the start of an Nk group; the 256-bit mid-group step substitutes unrotated
    assign sub_in = (grp == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data (sub_in[8*b +: 8]),
            .sub  (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_word;
        if (grp == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (nk == 6'd8 && grp == 3'd4) begin
            temp = sub_out;
        end
    end

    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_pack
        assign words[1919-32*g -: 32] = w[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_128;
            idx         <= 6'd0;
            grp         <= 3'd0;
            rcon        <= 8'h00;
            words_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) begin
                w[k] <= 32'h0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_BAD) begin
                            err <= 1'b1;
                        end else begin
                            mode_q <= mode;
                            for (int k = 0; k < MAX_WORDS; k++) begin
                                w[k] <= 32'h0;
                            end
                            for (int k = 0; k < 8; k++) begin
                                if (6'(k) < nk_of(mode)) begin
                                    w[k] <= key[255-32*k -: 32];
                                end
                            end
                            idx         <= nk_of(mode);
                            grp         <= 3'd0;
                            rcon        <= 8'h01;
                            words_valid <= 1'b0;
                            busy        <= 1'b1;
                            state       <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    w[idx] <= back_word ^ temp;
                    idx    <= idx + 6'd1;
                    grp    <= ({3'b000, grp} == nk - 6'd1) ? 3'd0 : grp + 3'd1;
                    if (grp == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (idx == last_idx) begin
                        state       <= ST_IDLE;
                        done        <= 1'b1;
                        words_valid <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - scoreboard bench for aes_key_schedule_seq against a GF(2^8) reference model
module tb_aes_key_schedule_seq;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [255:0]  key = '0;
    logic [1919:0] words;
    logic          words_valid;
    logic          busy;
    logic          done;
    logic          err;

    aes_key_schedule_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .key         (key),
        .words       (words),
        .words_valid (words_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1919:0] w;
        int            due;
    } exp_t;

    exp_t          sbq[$];
    int            errq[$];
    logic [7:0]    sb [256];
    logic [1919:0] last_exp;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (a != 8'h00 && gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [31:0] wd(input logic [1919:0] v, input int i);
        return v[1919-32*i -: 32];
    endfunction

    function automatic int nk_for(input int m);
        return (m == 0) ? 4 : (m == 1) ? 6 : 8;
    endfunction

    function automatic logic [1919:0] model(input logic [255:0] k, input int m);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] r = '0;
        int nk = nk_for(m);
        int total_words = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < total_words; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) r[1919-32*i -: 32] = w[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_words(input string name, input logic [1919:0] act, input logic [1919:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int i = 0; i < 60; i++) begin
                if (wd(act, i) !== wd(exp, i)) begin
                    $display("FAIL %s: w[%0d] got %08h expected %08h", name, i, wd(act, i), wd(exp, i));
                    break;
                end
            end
        end
    endtask

    // must be called right after a negedge; start is seen at the following posedge
    task automatic launch(input logic [255:0] k, input int m);
        exp_t e;
        int nk = nk_for(m);
        start = 1'b1;
        mode  = 2'(m);
        key   = k;
        e.w   = model(k, m);
        e.due = cyc + 1 + 4 * (nk + 7) - nk;
        last_exp = e.w;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("done_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin : monitor
        exp_t e;
        int   due;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check_words("schedule", words, e.w);
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("valid_at_done", 64'(words_valid), 64'd1);
                    check("busy_at_done", 64'(busy), 64'd0);
                end
            end
            if (rst_n && err) begin
                if (errq.size() == 0) begin
                    check("unexpected_err", 64'd1, 64'd0);
                end else begin
                    due = errq.pop_front();
                    check("err_cycle", 64'(cyc), 64'(due));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        for (int a = 0; a < 256; a++) sb[a] = sbox_calc(8'(a));

        repeat (3) @(negedge clk);
        check("reset_words_zero", 64'(words == '0), 64'd1);
        check("reset_valid", 64'(words_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0);
        @(negedge clk);
        check("busy_during_run", 64'(busy), 64'd1);
        check("valid_dropped", 64'(words_valid), 64'd0);
        wait_idle();
        check("k128_w40", 64'(wd(words, 40)), 64'h13111d7f);
        check("k128_w41", 64'(wd(words, 41)), 64'he3944a17);
        check("k128_w42", 64'(wd(words, 42)), 64'hf307a78b);
        check("k128_w43", 64'(wd(words, 43)), 64'h4d2b30c5);
        check("k128_upper_zero", 64'(words[511:0] == '0), 64'd1);

        launch({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1);
        wait_idle();
        check("k192_w48", 64'(wd(words, 48)), 64'ha4970a33);
        check("k192_w51", 64'(wd(words, 51)), 64'he3a41d5d);

        launch(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2);
        wait_idle();
        check("k256_w56", 64'(wd(words, 56)), 64'h24fc79cc);
        check("k256_w59", 64'(wd(words, 59)), 64'h6d68de36);

        launch({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0);
        wait_idle();
        check("fips_w4", 64'(wd(words, 4)), 64'ha0fafe17);
        check("fips_w43", 64'(wd(words, 43)), 64'hb6630ca6);

        // start mid-run with another key must be ignored; then start in the done cycle
        launch(rand_key(), 2);
        repeat (10) @(negedge clk);
        start = 1'b1;
        mode  = 2'b00;
        key   = rand_key();
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        launch(rand_key(), 1);
        wait_idle();

        start = 1'b1;
        mode  = 2'b11;
        key   = rand_key();
        errq.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 64'(err), 64'd1);
        check("err_busy", 64'(busy), 64'd0);
        check("err_valid_kept", 64'(words_valid), 64'd1);
        check_words("err_words_kept", words, last_exp);
        @(negedge clk);
        check("err_one_cycle", 64'(err), 64'd0);

        // asynchronous reset part-way through a 256-bit run
        launch(rand_key(), 2);
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        check("abort_words_zero", 64'(words == '0), 64'd1);
        check("abort_valid", 64'(words_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("no_done_after_abort", 64'(words_valid), 64'd0);
        launch(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2);
        wait_idle();
        check("rerun_w56", 64'(wd(words, 56)), 64'h24fc79cc);

        for (int r = 0; r < 6; r++) begin
            launch(rand_key(), int'($urandom_range(0, 2)));
            wait_idle();
        end

        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        check("err_queue_drained", 64'(errq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Sequential AES key expansion engine that sits directly upstream of the cipher and decipher datapaths. It accepts a 128-, 192- or 256-bit cipher key and produces the full round-key word array, one 32-bit word per clock. A shared set of four S-box lookups replaces the fully combinational expansion network. The result is a single bus that the `Cipher` and `DeCipher` instances consume unchanged once `words_valid` is high.

## Interface

Parameters:
- none; key size is selected at run time through `mode`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request expansion; sampled only in IDLE.
- `mode` in 2: key size. 2'b00 = 128 (Nk=4, Nr=10), 2'b01 = 192 (Nk=6, Nr=12), 2'b10 = 256 (Nk=8, Nr=14), 2'b11 = illegal.
- `key` in 256: cipher key, MSB-aligned.
  - 128-bit key in `key[255:128]`; 192-bit key in `key[255:64]`.
  - Unused low bits are ignored.
- `words` out 1920: round-key words w[0..59], MSB-first. w[i] occupies `words[1919-32*i -: 32]`.
  - A consumer with Nr rounds takes the top 128*(Nr+1) bits.
- `words_valid` out 1: high while `words` holds a complete schedule for the last accepted key.
- `busy` out 1: high in EXPAND.
- `done` out 1: one-cycle pulse when the last word is written.
- `err` out 1: one-cycle pulse when `start` is issued with `mode` = 2'b11.

## Operation

- States: IDLE, EXPAND.
- IDLE, `start`=1, legal mode:
  - Latch `mode`.
  - Clear all 60 words and write w[0..Nk-1] from `key`, all in the same edge.
  - Set i = Nk, j = 0 (position within the current Nk group), rcon = 8'h01.
  - Drop `words_valid`, raise `busy`, go to EXPAND.
- IDLE, `start`=1, mode 2'b11: pulse `err`. Nothing else changes; `words`/`words_valid` are retained.
- EXPAND: each cycle compute temp from w[i-1]:
  - j==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. Then rcon = xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Nk==8 and j==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - Write w[i] = w[i-Nk] ^ temp.
  - Advance i. Advance j, wrapping from Nk-1 to 0; no modulo/divide hardware.
- Last word index is 4*(Nr+1)-1, i.e. 43, 51 or 59.
  - On writing it: return to IDLE, pulse `done`, set `words_valid`, clear `busy`.
- `start` during EXPAND is ignored (no queuing). `mode` and `key` changes during EXPAND have no effect.
- Words above the last index stay 0.

## Timing

- Reset values: `words`=0, `words_valid`=0, `busy`=0, `done`=0, `err`=0, state IDLE. Internal i, j and rcon are also cleared.
- Reset mid-expansion clears everything immediately. No `done` is produced for the aborted run.
- Latency from the accepting edge to the edge that raises `done`/`words_valid`:
  - 40 cycles for 128-bit keys;
  - 46 cycles for 192-bit keys;
  - 52 cycles for 256-bit keys.
- `done` is high during the first IDLE cycle. A `start` in that same cycle is accepted, giving back-to-back runs.
- The S-box path is combinational within one cycle: register → 4 S-box lookups → XOR → register.

## Structure

- Shared package `aes_pkg`:
  - NK/NR per mode;
  - mode encodings;
  - MAX_WORDS = 60;
  - the xtime function.
- Sub-module `aes_sbox`: 8-bit forward S-box ROM, reused by `Cipher`. Instantiated four times for SubWord.

## Test plan

- Reset, then 128-bit key 000102030405060708090a0b0c0d0e0f:
  - `done` arrives 40 cycles after start;
  - w[40..43] = 13111d7f e3944a17 f307a78b 4d2b30c5;
  - `words[511:0]` = 0.
- 192-bit key 000102…1617: w[48..51] = a4970a33 1a78dc09 c418c271 e3a41d5d after 46 cycles.
- 256-bit key 000102…1e1f, then FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - 256-bit run: w[56..59] = 24fc79cc bf0979e9 371ac23c 6d68de36;
  - FIPS key run: w[4] = a0fafe17 and w[43] = b6630ca6.
- `start` pulsed mid-run (and with a changed key): ignored; the original schedule completes correctly; a start in the `done` cycle launches a second run.
- mode 2'b11 start: `err` pulses for one cycle; `busy` stays 0; a prior valid schedule is retained.
- `rst_n` dropped at cycle 20 of a 256-bit run:
  - all outputs go to 0 asynchronously;
  - a fresh start completes with correct words.
